// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: data-memory access sequencer for the multicycle CPU.
// Handles LW/LH/LHU/LB/LBU/SW/SH/SB against a word-wide memory with a fixed
// read latency. Sub-word loads are extended to 32 bits. Sub-word stores are
// done as read-modify-write of the containing word.
//
// Optional feature: define MISALIGN_EXC_EN to flag misaligned LW/SW/LH/LHU/SH
// with a one-cycle err pulse (no memory traffic). When it is undefined, err
// stays 0 and the offending low address bits are ignored.
module mem_access_ctrl #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    // RD lasts MEM_LATENCY cycles; the counter runs from MEM_LATENCY-1 down to 0
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [3:0]  cnt;
    logic        misal;

    function automatic logic is_load(input logic [2:0] lop);
        return (lop <= OP_LBU);
    endfunction

    // Select the addressed byte/halfword and extend it to 32 bits. Halfword
    // selection uses addr[1] only, so a stray addr[0] is ignored here.
    function automatic logic [31:0] load_extend(input logic [2:0]  lop,
                                                input logic [31:0] word,
                                                input logic [1:0]  off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] bs;
        logic signed [31:0] hs;
        b  = word[{off, 3'b000} +: 8];
        h  = word[{off[1], 4'b0000} +: 16];
        bs = b;
        hs = h;
        case (lop)
            OP_LB:   return bs;
            OP_LBU:  return {24'b0, b};
            OP_LH:   return hs;
            OP_LHU:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    // Replace one lane of the word just read with the store data.
    function automatic logic [31:0] merge_store(input logic [2:0]  sop,
                                                input logic [31:0] word,
                                                input logic [15:0] wd,
                                                input logic [1:0]  off);
        logic [31:0] w;
        w = word;
        if (sop == OP_SH) begin
            w[{off[1], 4'b0000} +: 16] = wd;
        end else begin
            w[{off, 3'b000} +: 8] = wd[7:0];
        end
        return w;
    endfunction

`ifdef MISALIGN_EXC_EN
    // Words need addr[1:0]=0, halfwords need addr[0]=0; bytes are always aligned.
    function automatic logic misaligned(input logic [2:0] mop, input logic [1:0] off);
        case (mop)
            OP_LW, OP_SW:         return (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: return off[0];
            default:              return 1'b0;
        endcase
    endfunction

    assign misal = misaligned(op, addr[1:0]);
`else
    assign misal = 1'b0;
`endif

    // Access sequencer: all outputs are registered and change with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_wr    <= 1'b0;
            rdata     <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            op_q      <= OP_LW;
            off_q     <= 2'b00;
            wdata_q   <= 16'd0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q     <= op;
                        off_q    <= addr[1:0];
                        wdata_q  <= wdata[15:0];
                        mem_addr <= {addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (misal) begin
                            // Rejected access: report immediately, touch nothing
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (op == OP_SW) begin
                            // Full-word store needs no read
                            state     <= WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state <= RD;
                            cnt   <= CNT_INIT;
                        end
                    end
                end

                RD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (is_load(op_q)) begin
                        rdata <= load_extend(op_q, mem_rdata, off_q);
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        // SH/SB: write back the merged word next cycle
                        mem_wdata <= merge_store(op_q, mem_rdata, wdata_q, off_q);
                        mem_wr    <= 1'b1;
                        state     <= WR;
                    end
                end

                WR: begin
                    mem_wr <= 1'b0;
                    state  <= DONE;
                    done   <= 1'b1;
                end

                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed cases plus randomized accesses,
// checked against a word-array reference model kept in the bench.
module tb_mem_access_ctrl;

    localparam int LAT = 3;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LATENCY(LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory: 16 words, aliased over the address space, with a backdoor port
    logic [31:0] mem [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = 4'd0;
    logic [31:0] bd_val = 32'd0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        else if (mem_wr) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
    end

    assign mem_rdata = mem[mem_addr[5:2]];

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata = 32'd0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_misaligned(input logic [2:0] o, input logic [31:0] a);
        logic r;
        r = 1'b0;
        if ((o == OP_LW || o == OP_SW) && (a % 4 != 0)) r = 1'b1;
        if ((o == OP_LH || o == OP_LHU || o == OP_SH) && (a % 2 != 0)) r = 1'b1;
`ifdef MISALIGN_EXC_EN
        return r;
`else
        return r & 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] word,
                                             input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] hw;
        int unsigned k;
        int unsigned h;
        k  = a % 4;
        h  = (a / 2) % 2;
        b  = (word >> (8 * k)) & 32'hFF;
        hw = (word >> (16 * h)) & 32'hFFFF;
        case (o)
            OP_LH:   return (hw >= 32'h8000) ? hw - 32'h10000 : hw;
            OP_LHU:  return hw;
            OP_LB:   return (b >= 32'h80) ? b - 32'h100 : b;
            OP_LBU:  return b;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] o, input logic [31:0] word,
                                              input logic [31:0] wd, input logic [31:0] a);
        logic [31:0] mask;
        int unsigned k;
        int unsigned h;
        k = a % 4;
        h = (a / 2) % 2;
        case (o)
            OP_SH: begin
                mask = 32'hFFFF << (16 * h);
                return (word & ~mask) | ((wd & 32'hFFFF) << (16 * h));
            end
            OP_SB: begin
                mask = 32'hFF << (8 * k);
                return (word & ~mask) | ((wd & 32'hFF) << (8 * k));
            end
            default: return wd;
        endcase
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        bd_we  = 1'b1;
        bd_idx = idx[3:0];
        bd_val = val;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One complete access; optionally pulses a second req while busy
    task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                          input bit glitch, output logic [31:0] got_rdata);
        int idx;
        int exp_lat;
        int exp_wr;
        int wr0;
        int lat;
        logic mis;
        idx = int'((a >> 2) % 16);
        mis = ref_misaligned(o, a);
        if (mis) begin
            exp_lat = 1;
            exp_wr  = 0;
        end else if (o <= OP_LBU) begin
            exp_lat   = LAT + 1;
            exp_wr    = 0;
            exp_rdata = ref_load(o, ref_mem[idx], a);
        end else if (o == OP_SW) begin
            exp_lat = 2;
            exp_wr  = 1;
            ref_mem[idx] = ref_store(o, ref_mem[idx], wd, a);
        end else begin
            exp_lat = LAT + 2;
            exp_wr  = 1;
            ref_mem[idx] = ref_store(o, ref_mem[idx], wd, a);
        end
        wr0 = wr_cnt;
        lat = 0;
        @(negedge clk);
        req   = 1'b1;
        op    = o;
        addr  = a;
        wdata = wd;
        @(posedge clk);
        #1;
        req   = 1'b0;
        op    = 3'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == 1) begin
                check("busy_after_accept", {31'd0, busy}, 32'd1);
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
            end
            if (glitch && c == 1) begin
                req   = 1'b1;
                op    = OP_SW;
                addr  = $urandom;
                wdata = $urandom;
            end
            if (glitch && c == 2) req = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        req = 1'b0;
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("err", {31'd0, err}, {31'd0, mis});
        check("busy_in_done", {31'd0, busy}, 32'd1);
        check("rdata", rdata, exp_rdata);
        check("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
        check("mem_word", mem[idx], ref_mem[idx]);
        got_rdata = rdata;
        @(posedge clk);
        #1;
        check("done_clears", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  ro;
        int          wr0;
        reset = 1'b1;
        req   = 1'b0;
        op    = OP_LW;
        addr  = 32'd0;
        wdata = 32'd0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        preload(4, 32'hDEADBEEF);
        access(OP_LW, 32'h10, 32'h0, 1'b0, r);
        check("lw_spec", r, 32'hDEADBEEF);
        preload(4, 32'h80FF7F01);
        access(OP_LB, 32'h13, 32'h0, 1'b0, r);
        check("lb_spec", r, 32'hFFFFFF80);
        access(OP_LBU, 32'h13, 32'h0, 1'b0, r);
        check("lbu_spec", r, 32'h00000080);
        access(OP_LH, 32'h10, 32'h0, 1'b0, r);
        check("lh_lo_spec", r, 32'h00007F01);
        access(OP_LH, 32'h12, 32'h0, 1'b0, r);
        check("lh_hi_spec", r, 32'hFFFF80FF);
        preload(8, 32'h11223344);
        access(OP_SH, 32'h22, 32'h1234ABCD, 1'b0, r);
        check("sh_spec", mem[8], 32'hABCD3344);
        preload(8, 32'h11223344);
        access(OP_SB, 32'h21, 32'h000000EE, 1'b0, r);
        check("sb_spec", mem[8], 32'h1122EE44);
        access(OP_LW, 32'h11, 32'h0, 1'b0, r);
`ifndef MISALIGN_EXC_EN
        check("lw_misaligned_word", r, 32'h80FF7F01);
`endif
        // Second request pulsed while busy must not start another access
        access(OP_SB, 32'h22, 32'h00000055, 1'b1, r);
        access(OP_LW, 32'h20, 32'h0, 1'b1, r);

        // Reset during the read phase of an SB aborts without writing
        wr0 = wr_cnt;
        @(negedge clk);
        req   = 1'b1;
        op    = OP_SB;
        addr  = 32'h21;
        wdata = 32'h77;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("rst_rd_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rdata = 32'd0;
        check("rst_rd_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_rd_done", {31'd0, done}, 32'd0);
        check("rst_rd_rdata", rdata, 32'd0);
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("rst_rd_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("rst_rd_mem", mem[8], ref_mem[8]);

        // Randomized accesses
        for (int t = 0; t < 200; t++) begin
            ro = 3'($urandom);
            access(ro, $urandom, $urandom, ($urandom % 8) == 0, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
